fetch_unit: RTL and testbench

Instruction fetch stage directly upstream of the multicycle control FSM. Holds the program counter and instruction register, fetches from instruction memory over a req/ack handshake, and applies absolute or relative branch updates. Consumes the controller's PC_RST, PC_WRITE, PC_SEL and BR_SEL, and produces OPCODE and MM for it.

---
 rtl/fetch_unit_if.sv | 12 +
 rtl/fetch_unit.sv | 123 ++++++++++++
 tb/tb_fetch_unit.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Instruction-memory read port: registered request/address out, data/ack pulse back.
interface fetch_unit_if #(
  parameter int ADDR_W = 16
);
  logic              req;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       rdata;
  logic              ack;

  modport master (output req, output addr, input rdata, input ack);
  modport slave  (input req, input addr, output rdata, output ack);
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC and instruction register, one memory read per PC_WRITE
// high period, absolute or PC-relative branch updates from the controller.
//
// state | meaning
// IDLE  | no read outstanding; branches and fetch start accepted
// REQ   | read outstanding, waiting for ack or timeout
// HOLD  | read finished; waiting for pc_write to drop, branches accepted
module fetch_unit #(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                TIMEOUT  = 8
) (
  input  logic              clk,
  input  logic              rst_f,
  input  logic              pc_rst,
  input  logic              pc_write,
  input  logic              pc_sel,
  input  logic              br_sel,
  fetch_unit_if.master      imem,
  output logic [31:0]       instr,
  output logic [3:0]        opcode,
  output logic [3:0]        mm,
  output logic [ADDR_W-1:0] pc,
  output logic              ir_valid,
  output logic              fetch_err
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] br_target;
  logic [CNT_W-1:0]  cnt;
  logic              br_taken;
  logic              fetch_start;
  logic              ack_hit;
  logic              tmo_hit;
  logic              br_take;

  assign imem.req  = (state == REQ);
  assign imem.addr = addr_q;
  assign opcode    = instr[31:28];
  assign mm        = instr[27:24];

  // Offset is ADDR_W bits wide, so modulo-2^ADDR_W addition is the sign-extended add.
  assign br_target = br_sel ? instr[ADDR_W-1:0] : pc + instr[ADDR_W-1:0];

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    fetch_start = 1'b0;
    ack_hit     = 1'b0;
    tmo_hit     = 1'b0;
    br_take     = 1'b0;
    case (state)
      IDLE: begin
        br_take = pc_sel && !br_taken;
        if (pc_write) begin
          fetch_start = 1'b1;
          state_nxt   = REQ;
        end
      end
      REQ: begin
        if (imem.ack) begin
          ack_hit   = 1'b1;
          state_nxt = HOLD;
        end else if (cnt == '0) begin
          tmo_hit   = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        br_take = pc_sel && !br_taken;
        if (!pc_write) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (pc_rst) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      pc        <= RESET_PC;
      instr     <= '0;
      addr_q    <= RESET_PC;
      cnt       <= '0;
      br_taken  <= 1'b0;
      ir_valid  <= 1'b0;
      fetch_err <= 1'b0;
    end else if (pc_rst) begin
      // fetch_err is deliberately sticky across a controller PC clear
      pc       <= RESET_PC;
      instr    <= '0;
      cnt      <= '0;
      br_taken <= 1'b0;
      ir_valid <= 1'b0;
    end else begin
      ir_valid <= ack_hit | tmo_hit;
      if (ack_hit || tmo_hit) begin
        instr    <= ack_hit ? imem.rdata : 32'h0;
        pc       <= addr_q + ADDR_W'(1);
        br_taken <= 1'b0;
        if (tmo_hit) fetch_err <= 1'b1;
      end else if (br_take) begin
        pc       <= br_target;
        br_taken <= 1'b1;
      end
      if (fetch_start) begin
        addr_q <= br_take ? br_target : pc;
        cnt    <= CNT_W'(TIMEOUT - 1);
      end else if (state == REQ && cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, hand-written corner sequences,
// then random fetch/branch/clear operations against a transaction-level model.
module tb_fetch_unit;
  localparam int ADDR_W  = 16;
  localparam int TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        rst_f, pc_rst, pc_write, pc_sel, br_sel;
  logic [31:0] instr;
  logic [3:0]  opcode, mm;
  logic [15:0] pc;
  logic        ir_valid, fetch_err;
  int          n_checks = 0;
  int          n_fail   = 0;

  fetch_unit_if #(.ADDR_W(ADDR_W)) imem ();

  fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC(16'h0000), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_f(rst_f), .pc_rst(pc_rst), .pc_write(pc_write),
    .pc_sel(pc_sel), .br_sel(br_sel), .imem(imem), .instr(instr),
    .opcode(opcode), .mm(mm), .pc(pc), .ir_valid(ir_valid), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;      // 0 fetch, 1 branch, 2 pc_rst
    logic        br;        // branch: br_sel; fetch: pc_sel held during REQ
    int          waits;     // fetch wait states (>= TIMEOUT means never ack)
    int          hold;      // fetch: pc_write cycles; branch: pc_sel cycles
    logic [31:0] data;
    logic [15:0] exp_addr;
    logic [15:0] exp_pc;
    logic [31:0] exp_instr;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] tgt(input logic br, input logic [15:0] p, input logic [31:0] ins);
    int off;
    off = int'($signed(ins[15:0]));
    if (br) return ins[15:0];
    return 16'((int'(p) + off) & 32'h0000FFFF);
  endfunction

  task automatic do_fetch(input int waits, input logic [31:0] data, input int hold,
                          input logic br_now, input logic br, input logic sel_req,
                          input logic [15:0] exp_addr, input logic [15:0] exp_pc,
                          input logic [31:0] exp_instr, input logic exp_err);
    int          reqs = 0;
    int          pulses = 0;
    int          pulse_at = -1;
    int          exp_reqs;
    logic [15:0] addr_seen = '0;
    logic [31:0] ei;
    ei       = exp_instr;
    exp_reqs = (waits < TIMEOUT) ? waits + 1 : TIMEOUT;
    @(negedge clk);
    pc_write = 1'b1;
    pc_sel   = br_now;
    br_sel   = br;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      imem.ack = 1'b0;
      if (ir_valid) begin
        pulses++;
        pulse_at = c;
      end
      if (imem.req) begin
        reqs++;
        addr_seen = imem.addr;
        if (reqs == waits + 1 && waits < TIMEOUT) begin
          imem.ack   = 1'b1;
          imem.rdata = data;
        end
      end
      pc_sel = sel_req && imem.req;
      if (c == hold) pc_write = 1'b0;
    end
    chk("fetch_req_cycles", 32'(reqs), 32'(exp_reqs));
    chk("fetch_addr", 32'(addr_seen), 32'(exp_addr));
    chk("ir_valid_pulses", 32'(pulses), 32'd1);
    chk("ir_valid_timing", 32'(pulse_at), 32'(exp_reqs + 1));
    chk("fetch_pc", 32'(pc), 32'(exp_pc));
    chk("fetch_instr", instr, ei);
    chk("fetch_opcode", 32'(opcode), 32'(ei[31:28]));
    chk("fetch_mm", 32'(mm), 32'(ei[27:24]));
    chk("fetch_err", 32'(fetch_err), 32'(exp_err));
  endtask

  task automatic do_branch(input logic br, input int cycles, input logic [15:0] exp_pc);
    @(negedge clk);
    pc_sel = 1'b1;
    br_sel = br;
    for (int c = 1; c <= cycles; c++) begin
      @(negedge clk);
      if (c == 1) chk("branch_pc_first_edge", 32'(pc), 32'(exp_pc));
      if (c == cycles) pc_sel = 1'b0;
    end
    @(negedge clk);
    chk("branch_pc", 32'(pc), 32'(exp_pc));
    chk("branch_no_req", 32'(imem.req), 32'd0);
  endtask

  task automatic do_pc_rst(input logic exp_err);
    @(negedge clk);
    pc_rst = 1'b1;
    @(negedge clk);
    pc_rst = 1'b0;
    chk("pc_rst_pc", 32'(pc), 32'h0);
    chk("pc_rst_instr", instr, 32'h0);
    chk("pc_rst_err", 32'(fetch_err), 32'(exp_err));
    chk("pc_rst_ir_valid", 32'(ir_valid), 32'd0);
  endtask

  initial begin
    logic [15:0] m_pc;
    logic [31:0] m_instr;
    logic        m_err, m_flag;

    rst_f = 1'b0; pc_rst = 1'b0; pc_write = 1'b0; pc_sel = 1'b0; br_sel = 1'b0;
    imem.ack = 1'b0; imem.rdata = '0;

    vecs.push_back('{0, 1'b0, 0, 1,  32'h81230005, 16'h0000, 16'h0001, 32'h81230005, 1'b0});
    vecs.push_back('{0, 1'b1, 3, 10, 32'h40000020, 16'h0001, 16'h0002, 32'h40000020, 1'b0});
    vecs.push_back('{1, 1'b1, 0, 3,  32'h0,        16'h0,    16'h0020, 32'h0,        1'b0});
    vecs.push_back('{1, 1'b0, 0, 1,  32'h0,        16'h0,    16'h0020, 32'h0,        1'b0});
    vecs.push_back('{0, 1'b0, 1, 2,  32'h0000000F, 16'h0020, 16'h0021, 32'h0000000F, 1'b0});
    vecs.push_back('{1, 1'b1, 0, 1,  32'h0,        16'h0,    16'h000F, 32'h0,        1'b0});
    vecs.push_back('{0, 1'b0, 0, 1,  32'h1200FFFC, 16'h000F, 16'h0010, 32'h1200FFFC, 1'b0});
    vecs.push_back('{1, 1'b0, 0, 2,  32'h0,        16'h0,    16'h000C, 32'h0,        1'b0});
    vecs.push_back('{0, 1'b1, 2, 3,  32'h0000FFFF, 16'h000C, 16'h000D, 32'h0000FFFF, 1'b0});
    vecs.push_back('{1, 1'b1, 0, 1,  32'h0,        16'h0,    16'hFFFF, 32'h0,        1'b0});
    vecs.push_back('{0, 1'b0, 0, 1,  32'hA5000000, 16'hFFFF, 16'h0000, 32'hA5000000, 1'b0});
    vecs.push_back('{0, 1'b0, 8, 1,  32'h0,        16'h0000, 16'h0001, 32'h00000000, 1'b1});
    vecs.push_back('{2, 1'b0, 0, 0,  32'h0,        16'h0,    16'h0000, 32'h0,        1'b1});
    vecs.push_back('{0, 1'b0, 0, 1,  32'h70000000, 16'h0000, 16'h0001, 32'h70000000, 1'b1});

    repeat (3) @(negedge clk);
    chk("reset_pc", 32'(pc), 32'h0);
    chk("reset_instr", instr, 32'h0);
    chk("reset_addr", 32'(imem.addr), 32'h0);
    chk("reset_req", 32'(imem.req), 32'd0);
    chk("reset_ir_valid", 32'(ir_valid), 32'd0);
    chk("reset_err", 32'(fetch_err), 32'd0);
    rst_f = 1'b1;

    foreach (vecs[i]) begin
      case (vecs[i].kind)
        0: do_fetch(vecs[i].waits, vecs[i].data, vecs[i].hold, 1'b0, 1'b0, vecs[i].br,
                    vecs[i].exp_addr, vecs[i].exp_pc, vecs[i].exp_instr, vecs[i].exp_err);
        1: do_branch(vecs[i].br, vecs[i].hold, vecs[i].exp_pc);
        default: do_pc_rst(vecs[i].exp_err);
      endcase
    end

    // PC_RST in the same cycle as ACK: the returned word must be dropped
    @(negedge clk);
    pc_write = 1'b1;
    @(negedge clk);
    chk("pcrst_ack_req", 32'(imem.req), 32'd1);
    imem.ack = 1'b1; imem.rdata = 32'hDEADBEEF; pc_rst = 1'b1; pc_write = 1'b0;
    @(negedge clk);
    imem.ack = 1'b0; pc_rst = 1'b0;
    chk("pcrst_ack_instr", instr, 32'h0);
    chk("pcrst_ack_pc", 32'(pc), 32'h0);
    chk("pcrst_ack_ir_valid", 32'(ir_valid), 32'd0);
    chk("pcrst_ack_req_drop", 32'(imem.req), 32'd0);
    chk("pcrst_ack_err_sticky", 32'(fetch_err), 32'd1);
    @(negedge clk);
    chk("pcrst_ack_ir_valid_late", 32'(ir_valid), 32'd0);

    // Asynchronous reset mid-REQ, then a late ACK while idle
    @(negedge clk);
    pc_write = 1'b1;
    @(negedge clk);
    chk("arst_req_before", 32'(imem.req), 32'd1);
    #2 rst_f = 1'b0;
    #1;
    chk("arst_req_immediate", 32'(imem.req), 32'd0);
    chk("arst_pc", 32'(pc), 32'h0);
    chk("arst_err_cleared", 32'(fetch_err), 32'd0);
    @(negedge clk);
    rst_f = 1'b1; pc_write = 1'b0; imem.ack = 1'b1; imem.rdata = 32'h12345678;
    @(negedge clk);
    imem.ack = 1'b0;
    chk("late_ack_instr", instr, 32'h0);
    chk("late_ack_ir_valid", 32'(ir_valid), 32'd0);
    chk("late_ack_pc", 32'(pc), 32'h0);

    m_pc = 16'h0; m_instr = 32'h0; m_err = 1'b0; m_flag = 1'b0;
    for (int n = 0; n < 120; n++) begin
      int          sel;
      sel = int'($urandom_range(0, 99));
      if (sel < 50) begin
        int          waits, hold;
        logic        br_now, br, sel_req;
        logic [31:0] data;
        logic [15:0] addr;
        waits   = int'($urandom_range(0, 9));
        hold    = int'($urandom_range(1, 12));
        data    = $urandom;
        br_now  = 1'($urandom_range(0, 1));
        br      = 1'($urandom_range(0, 1));
        sel_req = 1'($urandom_range(0, 1));
        addr    = (br_now && !m_flag) ? tgt(br, m_pc, m_instr) : m_pc;
        m_pc    = addr + 16'd1;
        if (waits < TIMEOUT) m_instr = data;
        else begin
          m_instr = 32'h0;
          m_err   = 1'b1;
        end
        m_flag = 1'b0;
        do_fetch(waits, data, hold, br_now, br, sel_req, addr, m_pc, m_instr, m_err);
      end else if (sel < 85) begin
        logic br;
        int   cycles;
        br     = 1'($urandom_range(0, 1));
        cycles = int'($urandom_range(1, 3));
        if (!m_flag) begin
          m_pc   = tgt(br, m_pc, m_instr);
          m_flag = 1'b1;
        end
        do_branch(br, cycles, m_pc);
      end else begin
        m_pc = 16'h0; m_instr = 32'h0; m_flag = 1'b0;
        do_pc_rst(m_err);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
